// File: rtl/pc_seq_pkg.sv
// Shared types and constants for the PC fetch/sequence controller.
// Holds the FSM state encoding, opcode values and PC mux selects.
package pc_seq_pkg;

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_WAIT   = 3'd3,
    S_UPDATE = 3'd4,
    S_HALT   = 3'd5
  } seq_state_e;

  localparam logic [3:0] OPC_BEQ  = 4'hA;
  localparam logic [3:0] OPC_BNE  = 4'hB;
  localparam logic [3:0] OPC_JMP  = 4'hC;
  localparam logic [3:0] OPC_HALT = 4'hF;

  localparam logic [1:0] PCSRC_SEQ = 2'b00;
  localparam logic [1:0] PCSRC_BR  = 2'b01;
  localparam logic [1:0] PCSRC_JMP = 2'b10;

endpackage

// File: rtl/pc_sequencer.sv
// Multicycle fetch/sequence controller: fetches at PCOut, latches IR, starts the
// datapath for non-control-flow instructions and issues one PC update each.
//
// state  | meaning
// FETCH  | mem_req high at PCOut, wait for mem_ready, latch IR
// DECODE | classify opcode
// EXEC   | one-cycle exec_start pulse
// WAIT   | wait for exec_done
// UPDATE | single PC update (sequential, jump or branch on Zero)
// HALT   | parked until reset
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter logic [3:0] OP_BEQ  = OPC_BEQ,
  parameter logic [3:0] OP_BNE  = OPC_BNE,
  parameter logic [3:0] OP_JMP  = OPC_JMP,
  parameter logic [3:0] OP_HALT = OPC_HALT
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [15:0] PCOut,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready,
  input  logic        exec_done,
  input  logic        Zero,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [15:0] IR,
  output logic        exec_start,
  output logic        PCWrite,
  output logic [1:0]  PCSrc,
  output logic        Branch,
  output logic        bneOrbeq,
  output logic        halted
);

  seq_state_e  state_q, state_d;
  logic [15:0] ir_q, ir_d;
  logic [3:0]  opc;

  assign opc      = ir_q[15:12];
  assign IR       = ir_q;
  assign mem_addr = PCOut;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready) begin
          ir_d    = mem_rdata;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (opc == OP_HALT)
          state_d = S_HALT;
        else if (opc == OP_BEQ || opc == OP_BNE || opc == OP_JMP)
          state_d = S_UPDATE;
        else
          state_d = S_EXEC;
      end
      S_EXEC:   state_d = S_WAIT;
      S_WAIT:   if (exec_done) state_d = S_UPDATE;
      S_UPDATE: state_d = S_FETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  // Strobes are masked by reset so the reset cycle itself never pulses.
  always_comb begin
    mem_req    = 1'b0;
    exec_start = 1'b0;
    PCWrite    = 1'b0;
    PCSrc      = PCSRC_SEQ;
    Branch     = 1'b0;
    bneOrbeq   = 1'b0;
    halted     = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: mem_req    = 1'b1;
        S_EXEC:  exec_start = 1'b1;
        S_HALT:  halted     = 1'b1;
        S_UPDATE: begin
          if (opc == OP_JMP) begin
            PCWrite = 1'b1;
            PCSrc   = PCSRC_JMP;
          end else if (opc == OP_BEQ || opc == OP_BNE) begin
            bneOrbeq = (opc == OP_BEQ);
            if ((opc == OP_BEQ) ? Zero : !Zero) begin
              Branch = 1'b1;
              PCSrc  = PCSRC_BR;
            end else begin
              PCWrite = 1'b1;
            end
          end else begin
            PCWrite = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: stimulus pushes expected PC-update records,
// a negedge monitor pops and compares whenever the DUT strobes PCWrite or Branch.
module tb_pc_sequencer;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] PCOut;
  logic [15:0] mem_rdata = '0;
  logic        mem_ready = 1'b0;
  logic        exec_done = 1'b0;
  logic        Zero = 1'b0;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] IR;
  logic        exec_start;
  logic        PCWrite;
  logic [1:0]  PCSrc;
  logic        Branch;
  logic        bneOrbeq;
  logic        halted;

  typedef struct packed {
    logic       pcw;
    logic       br;
    logic [1:0] src;
    logic       bneq;
  } upd_t;

  upd_t expq[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   exec_cnt = 0;
  logic [15:0] pc_model;

  always #5 CLK = ~CLK;

  pc_sequencer dut (
    .CLK(CLK), .reset(reset), .PCOut(PCOut), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .exec_done(exec_done), .Zero(Zero),
    .mem_req(mem_req), .mem_addr(mem_addr), .IR(IR), .exec_start(exec_start),
    .PCWrite(PCWrite), .PCSrc(PCSrc), .Branch(Branch), .bneOrbeq(bneOrbeq),
    .halted(halted)
  );

  // Environment model of the PC block reacting to the DUT controls.
  always @(posedge CLK) begin
    if (reset)        pc_model <= 16'h0100;
    else if (PCWrite) pc_model <= (PCSrc == 2'b10) ? 16'h0400 : pc_model + 16'd2;
    else if (Branch)  pc_model <= pc_model + 16'h0020;
  end
  assign PCOut = pc_model;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    upd_t got, exp;
    if (exec_start) exec_cnt++;
    if (mem_req) check("mem_addr", mem_addr, pc_model);
    if (PCWrite || Branch) begin
      got = '{pcw: PCWrite, br: Branch, src: PCSrc, bneq: bneOrbeq};
      if (expq.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL unexpected_update: got %b expected none", got);
      end else begin
        exp = expq.pop_front();
        check("update", {11'd0, got}, {11'd0, exp});
      end
    end
  end

  function automatic upd_t expect_upd(input logic [15:0] instr, input logic z);
    upd_t e = '{pcw: 1'b1, br: 1'b0, src: 2'b00, bneq: 1'b0};
    case (instr[15:12])
      4'hC: e.src = 2'b10;
      4'hA: begin e.bneq = 1'b1; if (z)  begin e.pcw = 1'b0; e.br = 1'b1; e.src = 2'b01; end end
      4'hB: begin                if (!z) begin e.pcw = 1'b0; e.br = 1'b1; e.src = 2'b01; end end
      default: ;
    endcase
    return e;
  endfunction

  // Entered just after a posedge with the DUT in FETCH.
  task automatic do_instr(input logic [15:0] instr, input logic z, input int rdly,
                          input int ddly, input int exp_starts);
    int since = -1;
    int c0;
    bit done = 0;
    if (instr[15:12] != 4'hF) expq.push_back(expect_upd(instr, z));
    Zero = z; mem_rdata = instr; mem_ready = 1'b0;
    repeat (rdly) begin @(posedge CLK); #1; end
    mem_ready = 1'b1;
    @(posedge CLK); #1;
    mem_ready = 1'b0;
    mem_rdata = 16'hDEAD;
    check("IR", IR, instr);
    c0 = exec_cnt;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge CLK);
      if (exec_start) since = 0; else if (since >= 0) since++;
      if (since >= ddly) exec_done = 1'b1;
      if (PCWrite || Branch || halted) done = 1;
    end
    if (!done) begin
      vectors++; miscompares++;
      $display("FAIL timeout: got no update expected one for %h", instr);
    end
    @(posedge CLK); #1;
    exec_done = 1'b0;
    check("exec_starts", 16'(exec_cnt - c0), 16'(exp_starts));
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    repeat (n) begin
      @(negedge CLK);
      check("rst_strobes", {10'd0, mem_req, exec_start, PCWrite, Branch, halted, bneOrbeq}, 16'd0);
      @(posedge CLK); #1;
    end
    reset = 1'b0;
    mem_ready = 1'b0;
  endtask

  initial begin
    int c0;
    mem_ready = 1'b1;
    do_reset(2);
    @(negedge CLK);
    check("rst_IR", IR, 16'h0000);
    check("rst_mem_req", {15'd0, mem_req}, 16'd1);
    check("rst_quiet", {11'd0, exec_start, PCWrite, Branch, PCSrc}, 16'd0);
    @(posedge CLK); #1;

    do_instr(16'h1234, 1'b0, 2, 3, 1);
    do_instr(16'hA005, 1'b1, 0, 0, 0);
    do_instr(16'hA005, 1'b0, 1, 0, 0);
    do_instr(16'hB000, 1'b0, 0, 0, 0);
    do_instr(16'hB000, 1'b1, 0, 0, 0);
    do_instr(16'hC010, 1'b0, 0, 0, 0);
    do_instr(16'h2100, 1'b1, 0, 0, 1);

    // Halt parks the sequencer; only reset leaves.
    do_instr(16'hF000, 1'b0, 0, 0, 0);
    mem_ready = 1'b1; exec_done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("halted", {10'd0, halted, mem_req, exec_start, PCWrite, Branch, bneOrbeq}, 16'h0020);
    end
    mem_ready = 1'b0; exec_done = 1'b0;
    @(posedge CLK); #1;
    do_reset(1);

    // Reset during WAIT must abandon the instruction without a PC update.
    Zero = 1'b0; mem_rdata = 16'h3333; mem_ready = 1'b1;
    @(posedge CLK); #1;
    mem_ready = 1'b0;
    check("IR_wait", IR, 16'h3333);
    c0 = exec_cnt;
    repeat (3) begin @(posedge CLK); #1; end
    do_reset(1);
    @(negedge CLK);
    check("wait_rst_exec", 16'(exec_cnt - c0), 16'd1);
    check("wait_rst_fetch", {14'd0, mem_req, PCWrite}, 16'd2);
    @(posedge CLK); #1;
    do_instr(16'hC000, 1'b0, 0, 0, 0);

    check("queue_empty", 16'(expq.size()), 16'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
